// File: rtl/proctypes.sv
// Shared raytracer/display types: screen geometry, framebuffer index and
// the pixel record carried from the raytracer into the framebuffer writer.
package proctypes;

    localparam int SCREEN_WIDTH  = 320;
    localparam int SCREEN_HEIGHT = 240;

    typedef logic [8:0] ScreenX;
    typedef logic [7:0] ScreenY;

    localparam int FB_INDEX_BITS = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT);

    typedef logic [FB_INDEX_BITS-1:0] FbIndex;

    typedef struct packed {
        ScreenX      x;
        ScreenY      y;
        logic [15:0] col;
    } PixelEntry;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITING,
        ST_WAIT_SWAP
    } fb_writer_state;

    function automatic logic is_last_pixel(input ScreenX x, input ScreenY y);
        return (x == ScreenX'(SCREEN_WIDTH - 1)) && (y == ScreenY'(SCREEN_HEIGHT - 1));
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO of PixelEntry records; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module pixel_fifo
    import proctypes::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    input  PixelEntry din,
    output PixelEntry dout
);

    localparam int AW = $clog2(DEPTH);

    PixelEntry        r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);
    assign dout      = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/framebuffer_writer.sv
// Buffers raytracer pixels and writes them into the back half of a
// double-buffered framebuffer, swapping halves at vsync after the last pixel.
module framebuffer_writer
    import proctypes::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int FB_INDEX_W = FB_INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  valid_in,
    input  ScreenX                pixel_x_in,
    input  ScreenY                pixel_y_in,
    input  logic [15:0]           pixel_value_in,
    input  logic                  vsync,
    output logic                  fb_we,
    input  logic                  fb_wr_ready,
    output logic [FB_INDEX_W:0]   fb_addr,
    output logic [15:0]           fb_wdata,
    output logic                  front_sel,
    output logic                  busy,
    output logic                  overflow,
    output logic [15:0]           frame_count
);

    fb_writer_state          r_state;
    logic                    r_pending_start;
    logic                    r_front_sel;
    logic                    r_overflow;
    logic                    r_we;
    logic                    r_last;
    logic [15:0]             r_frame_count;
    logic [15:0]             r_wdata;
    logic [FB_INDEX_W:0]     r_addr;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_xfer;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_accept;
    PixelEntry               w_din;
    PixelEntry               w_dout;
    logic [FB_INDEX_W-1:0]   w_index;

    assign w_din    = '{x: pixel_x_in, y: pixel_y_in, col: pixel_value_in};
    assign w_xfer   = r_we && fb_wr_ready;
    assign w_accept = valid_in && (r_state != ST_IDLE);
    // Nothing is popped on the cycle the last pixel leaves, so the next
    // frame's pixels are addressed with the post-swap buffer select.
    assign w_pop    = (r_state == ST_WRITING) && !w_empty &&
                      (!r_we || w_xfer) && !(w_xfer && r_last);
    assign w_push   = w_accept && (!w_full || w_pop);
    assign w_index  = FB_INDEX_W'(w_dout.y) * FB_INDEX_W'(SCREEN_WIDTH) + FB_INDEX_W'(w_dout.x);

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .full  (w_full),
        .empty (w_empty),
        .din   (w_din),
        .dout  (w_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_pending_start <= 1'b0;
            r_front_sel     <= 1'b0;
            r_overflow      <= 1'b0;
            r_we            <= 1'b0;
            r_last          <= 1'b0;
            r_frame_count   <= '0;
            r_wdata         <= '0;
            r_addr          <= '0;
        end else begin
            if (w_pop) begin
                r_we    <= 1'b1;
                r_addr  <= {~r_front_sel, w_index};
                r_wdata <= w_dout.col;
                r_last  <= is_last_pixel(w_dout.x, w_dout.y);
            end else if (w_xfer) begin
                r_we <= 1'b0;
            end

            if (w_accept && w_full && !w_pop) r_overflow <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (frame_start) begin
                        r_state    <= ST_WRITING;
                        r_overflow <= 1'b0;
                    end
                end
                ST_WRITING: begin
                    if (w_xfer && r_last) r_state <= ST_WAIT_SWAP;
                end
                ST_WAIT_SWAP: begin
                    if (vsync) begin
                        r_front_sel     <= ~r_front_sel;
                        r_frame_count   <= r_frame_count + 16'd1;
                        r_pending_start <= 1'b0;
                        r_state         <= (r_pending_start || frame_start) ? ST_WRITING : ST_IDLE;
                    end else if (frame_start) begin
                        r_pending_start <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign fb_we       = r_we;
    assign fb_addr     = r_addr;
    assign fb_wdata    = r_wdata;
    assign front_sel   = r_front_sel;
    assign busy        = (r_state != ST_IDLE);
    assign overflow    = r_overflow;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Bench for framebuffer_writer: directed scenarios plus random traffic, all
// compared each cycle against a queue-based model of the pixel path.
module tb_framebuffer_writer;
    import proctypes::*;

    localparam int W     = 320;
    localparam int H     = 240;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        valid_in;
    ScreenX      pixel_x_in;
    ScreenY      pixel_y_in;
    logic [15:0] pixel_value_in;
    logic        vsync;
    logic        fb_we;
    logic        fb_wr_ready;
    logic [17:0] fb_addr;
    logic [15:0] fb_wdata;
    logic        front_sel;
    logic        busy;
    logic        overflow;
    logic [15:0] frame_count;

    int n_checks = 0;
    int n_fail   = 0;
    int n_wr     = 0;
    int w0;

    framebuffer_writer dut (
        .clk            (clk),
        .rst            (rst),
        .frame_start    (frame_start),
        .valid_in       (valid_in),
        .pixel_x_in     (pixel_x_in),
        .pixel_y_in     (pixel_y_in),
        .pixel_value_in (pixel_value_in),
        .vsync          (vsync),
        .fb_we          (fb_we),
        .fb_wr_ready    (fb_wr_ready),
        .fb_addr        (fb_addr),
        .fb_wdata       (fb_wdata),
        .front_sel      (front_sel),
        .busy           (busy),
        .overflow       (overflow),
        .frame_count    (frame_count)
    );

    always #5 clk = ~clk;

    // Reference model: pending pixels as a queue plus one output slot.
    typedef struct { int x; int y; int col; } pix_t;
    pix_t        m_q[$];
    int          m_mode    = 0;   // 0 idle, 1 writing, 2 waiting for vsync
    bit          m_pending = 0;
    bit          m_front   = 0;
    bit          m_ovf     = 0;
    bit          m_we      = 0;
    bit          m_last    = 0;
    int          m_count   = 0;
    logic [17:0] m_addr    = '0;
    logic [15:0] m_data    = '0;

    always @(posedge clk) begin
        bit   xfer;
        bit   pop;
        bit   was_last;
        pix_t e;
        if (rst) begin
            m_q.delete();
            m_mode = 0; m_pending = 0; m_front = 0; m_ovf = 0;
            m_we = 0; m_last = 0; m_count = 0; m_addr = '0; m_data = '0;
        end else begin
            if (fb_we && fb_wr_ready) n_wr++;
            xfer     = m_we && fb_wr_ready;
            was_last = m_last;
            pop      = (m_mode == 1) && (m_q.size() > 0) && (!m_we || xfer) && !(xfer && was_last);
            if (pop) begin
                e      = m_q.pop_front();
                m_we   = 1;
                m_addr = {~m_front, 17'(e.y * W + e.x)};
                m_data = 16'(e.col);
                m_last = (e.x == W - 1) && (e.y == H - 1);
            end else if (xfer) begin
                m_we = 0;
            end
            if (m_mode != 0 && valid_in) begin
                if (m_q.size() < DEPTH) begin
                    e.x = int'(pixel_x_in); e.y = int'(pixel_y_in); e.col = int'(pixel_value_in);
                    m_q.push_back(e);
                end else begin
                    m_ovf = 1;
                end
            end
            case (m_mode)
                0: if (frame_start) begin m_mode = 1; m_ovf = 0; end
                1: if (xfer && was_last) m_mode = 2;
                default: begin
                    if (vsync) begin
                        m_front = ~m_front;
                        m_count = (m_count + 1) % 65536;
                        m_mode  = (m_pending || frame_start) ? 1 : 0;
                        m_pending = 0;
                    end else if (frame_start) begin
                        m_pending = 1;
                    end
                end
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("fb_we",       32'(fb_we),       32'(m_we));
        check("fb_addr",     32'(fb_addr),     32'(m_addr));
        check("fb_wdata",    32'(fb_wdata),    32'(m_data));
        check("front_sel",   32'(front_sel),   32'(m_front));
        check("busy",        32'(busy),        32'(m_mode != 0));
        check("overflow",    32'(overflow),    32'(m_ovf));
        check("frame_count", 32'(frame_count), 32'(m_count));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic send_pix(input int x, input int y, input int col);
        valid_in       = 1'b1;
        pixel_x_in     = 9'(x);
        pixel_y_in     = 8'(y);
        pixel_value_in = 16'(col);
        step();
        valid_in = 1'b0;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic pulse_vsync();
        vsync = 1'b1;
        step();
        vsync = 1'b0;
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; valid_in = 1'b0; vsync = 1'b0;
        pixel_x_in = '0; pixel_y_in = '0; pixel_value_in = '0; fb_wr_ready = 1'b1;
        step();
        step();
        check("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
        check("rst_we", 32'(fb_we), 32'd0);
        rst = 1'b0;

        // Pixels and vsync while idle are ignored.
        for (int i = 0; i < 3; i++) send_pix(i, 1, int'($urandom_range(0, 65535)));
        pulse_vsync();
        step();
        check("idle_writes", 32'(n_wr), 32'd0);

        // Single pixel latency and address.
        pulse_start();
        send_pix(3, 2, 16'hF800);
        check("lat_n1_we", 32'(fb_we), 32'd0);
        step();
        check("lat_n2_we", 32'(fb_we), 32'd1);
        check("single_addr", 32'(fb_addr), 32'h20283);
        check("single_data", 32'(fb_wdata), 32'hF800);
        step();
        step();

        // Backpressure: 1 in the output register, 8 in the FIFO, 10th dropped.
        fb_wr_ready = 1'b0;
        w0 = n_wr;
        for (int i = 0; i < 10; i++) send_pix(i, 5, int'($urandom_range(0, 65535)));
        check("ovf_set", 32'(overflow), 32'd1);
        step();
        step();
        check("stall_writes", 32'(n_wr - w0), 32'd0);
        fb_wr_ready = 1'b1;
        repeat (12) step();
        check("bp_writes", 32'(n_wr - w0), 32'd9);

        // Random traffic with random stalls and stray vsyncs while writing.
        for (int i = 0; i < 400; i++) begin
            fb_wr_ready    = ($urandom_range(0, 3) != 0);
            valid_in       = ($urandom_range(0, 1) != 0);
            vsync          = ($urandom_range(0, 15) == 0);
            pixel_x_in     = 9'($urandom_range(0, W - 2));
            pixel_y_in     = 8'($urandom_range(0, H - 1));
            pixel_value_in = 16'($urandom_range(0, 65535));
            step();
        end
        valid_in = 1'b0; vsync = 1'b0; fb_wr_ready = 1'b1;
        repeat (12) step();

        // Last pixel -> wait for vsync, with a pending start and 3 pixels.
        send_pix(10, 10, int'($urandom_range(0, 65535)));
        send_pix(W - 1, H - 1, int'($urandom_range(0, 65535)));
        repeat (4) step();
        check("ws_state", 32'(dut.r_state), 32'(ST_WAIT_SWAP));
        check("ws_front", 32'(front_sel), 32'd0);
        w0 = n_wr;
        pulse_start();
        for (int i = 0; i < 3; i++) send_pix(5 + i, 1, int'($urandom_range(0, 65535)));
        repeat (5) step();
        check("pend_nowr", 32'(n_wr - w0), 32'd0);
        pulse_vsync();
        check("pend_front", 32'(front_sel), 32'd1);
        check("pend_count", 32'(frame_count), 32'd1);
        check("pend_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (fb_we && fb_wr_ready) check("pend_msb", 32'(fb_addr[17]), 32'd0);
            step();
        end
        check("pend_writes", 32'(n_wr - w0), 32'd3);

        // Second swap without a pending start: busy drops with the toggle.
        send_pix(W - 1, H - 1, int'($urandom_range(0, 65535)));
        repeat (3) step();
        check("ws2_state", 32'(dut.r_state), 32'(ST_WAIT_SWAP));
        pulse_vsync();
        check("swap_front", 32'(front_sel), 32'd0);
        check("swap_count", 32'(frame_count), 32'd2);
        check("swap_busy", 32'(busy), 32'd0);

        // Reset while a write is stalled and the FIFO holds 4 pixels.
        fb_wr_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 5; i++) send_pix(20 + i, 7, int'($urandom_range(0, 65535)));
        step();
        check("mid_we_before", 32'(fb_we), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_we_after", 32'(fb_we), 32'd0);
        check("mid_fifo_empty", 32'(dut.w_empty), 32'd1);
        fb_wr_ready = 1'b1;
        w0 = n_wr;
        pulse_start();
        send_pix(1, 1, int'($urandom_range(0, 65535)));
        repeat (6) step();
        check("mid_writes", 32'(n_wr - w0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/framebuffer_writer.md
# framebuffer_writer

Downstream consumer of the raytracing controller's pixel stream. It buffers each `(pixel_x, pixel_y, pixel_value)` result in a small FIFO and writes it into a double-buffered framebuffer BRAM through a valid/ready write port. When the last pixel of a frame has been written, it swaps front and back buffers at the next display vsync. The raytracer has no backpressure, so the block absorbs memory stalls and flags overflow.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: pixel FIFO entries; must be a power of 2.
- `FB_INDEX_W`, default `$clog2(SCREEN_WIDTH*SCREEN_HEIGHT)`: width of the per-buffer pixel index.

Ports:
- Reset is synchronous and active-high; `clk` is the single clock.
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `frame_start`  in  1  pulse; a frame-render instruction was issued (same cycle as `execInst_valid && iType==opFrame`)
- `valid_in`  in  1  one-cycle pixel strobe from the raytracer
- `pixel_x_in`  in  ScreenX  pixel column
- `pixel_y_in`  in  ScreenY  pixel row
- `pixel_value_in`  in  16  RGB565 colour
- `vsync`  in  1  one-cycle pulse at display vertical blank
- `fb_we`  out  1  write request valid
- `fb_wr_ready`  in  1  BRAM write port accepts this cycle
- `fb_addr`  out  `FB_INDEX_W+1`  `{buffer_sel, y*SCREEN_WIDTH+x}`
- `fb_wdata`  out  16  pixel colour
- `front_sel`  out  1  buffer currently scanned out by the display
- `busy`  out  1  state != IDLE
- `overflow`  out  1  sticky; set when a pixel was dropped
- `frame_count`  out  16  completed, swapped frames (wraps)

## Operation
States:
- IDLE: no frame in progress. `valid_in` is ignored (no push, no overflow). `frame_start` → WRITING.
- WRITING: push on `valid_in`; pop into the output register whenever it is empty or being transferred. A transfer of pixel `(SCREEN_WIDTH-1, SCREEN_HEIGHT-1)` → WAIT_SWAP.
- WAIT_SWAP: FIFO pops are held. On `vsync`: toggle `front_sel`, increment `frame_count`, then go to WRITING if a frame start is pending, else IDLE.

Data path and arithmetic:
- Writes always target the back buffer; `fb_addr` MSB = `~front_sel`.
- Index = `pixel_y*SCREEN_WIDTH + pixel_x`. This is computed in the pop cycle, registered, and truncated to `FB_INDEX_W`. Width-extend before the multiply.

Boundary conditions:
- `frame_start` in WRITING: ignored.
- `frame_start` in WAIT_SWAP: sets `pending_start`. Pixels arriving meanwhile are pushed, but not popped until after the swap.
- Push while the FIFO is full and no pop happens that cycle: the pixel is dropped and `overflow` is set. A push into a full FIFO with a simultaneous pop is accepted.
- `overflow` clears only on `rst` or `frame_start` accepted from IDLE.
- `vsync` outside WAIT_SWAP: no effect.
- Reset mid-frame: FIFO is flushed, an in-flight `fb_we` is dropped, and all registers return to reset values.

Reset values: state IDLE, `fb_we` 0, `fb_addr` 0, `fb_wdata` 0, `front_sel` 0, `busy` 0, `overflow` 0, `frame_count` 0, `pending_start` 0, FIFO empty.

## Timing
- Latency: `valid_in` in cycle N with FIFO empty and `fb_wr_ready` high → `fb_we` high in cycle N+2. Cycle N+1 is the FIFO push; the pop and address register happen at the N+2 edge.
- Handshake: `fb_addr` and `fb_wdata` are stable while `fb_we && !fb_wr_ready`. The transfer occurs on a cycle where `fb_we && fb_wr_ready`.
- Throughput: 1 pixel/cycle sustained when `fb_wr_ready` is high.
- Swap: `front_sel` toggles on the clock edge after `vsync` is sampled in WAIT_SWAP. `busy` drops in the same cycle if no start is pending.

## Structure
- Shared package `proctypes` holds the following, reusing `ScreenX`, `ScreenY`, `SCREEN_WIDTH`, `SCREEN_HEIGHT`:
  - typedef `FbIndex` (`FB_INDEX_W` bits)
  - typedef `PixelEntry` struct `{ScreenX x; ScreenY y; logic[15:0] col;}`
  - enum `fb_writer_state`
- One sub-module, `pixel_fifo`: a synchronous FIFO of `PixelEntry`.
  - Ports: `push`, `pop`, `full`, `empty`, `din`, `dout`.
  - Push and pop allowed in the same cycle when full.

## Test plan
- Reset: assert `rst` 2 cycles → every output is 0 and state is IDLE. `valid_in` pulses while IDLE produce no `fb_we`.
- Single pixel: `frame_start`, then pixel (3,2)=16'hF800 at cycle N with ready high → `fb_we` at N+2. Taking `SCREEN_WIDTH=320` as the package value for this test, `fb_addr` = `{1'b1, 643}` and `fb_wdata` = F800.
- Backpressure/overflow: `fb_wr_ready` low, 10 back-to-back pixels.
  - The output register captures 1 pixel and the FIFO holds 8, so the 10th pixel is dropped and `overflow`=1.
  - Release ready → exactly 9 writes in input order, each with `fb_addr` held stable while stalled.
- Frame swap: stream a full frame ending with (W-1,H-1) → state WAIT_SWAP and `front_sel` still 0. Send `vsync` → `front_sel`=1, `frame_count`=1, and `busy` drops the next cycle.
- Pending start: `frame_start` plus 3 pixels during WAIT_SWAP → no `fb_we` before `vsync`. After the swap, the 3 writes go out with `fb_addr` MSB = 0.
- Reset mid-frame: `rst` during a stalled `fb_we` with the FIFO holding 4 pixels → next cycle `fb_we`=0 and the FIFO is empty. A following `frame_start` plus 1 pixel yields exactly 1 write.
